sort_result_checker: RTL

- Synthesizable, self-checking run monitor for the single-cycle CPU. Replaces ad-hoc testbench end-of-program checks.
- Watches the CPU PC and overflow flag until a programmable halt PC is reached, then reads an array from data memory through a read port and verifies ordering.
- Reports done, pass and an error code, usable on FPGA or in simulation.
- Generalised over data width, array base and length, sort direction, signedness, duplicate handling, overflow expectation and a watchdog.

---
 rtl/cpu_check_pkg.sv | 18 +
 rtl/order_cmp.sv | 29 ++
 rtl/sort_result_checker.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/cpu_check_pkg.sv
// Shared definitions for the CPU run checker.
//   err_t codes reported on err_code, and the checker FSM state encoding.
package cpu_check_pkg;

   localparam logic [2:0] ERR_NONE      = 3'd0;
   localparam logic [2:0] ERR_UNEXP_OVF = 3'd1;
   localparam logic [2:0] ERR_MISS_OVF  = 3'd2;
   localparam logic [2:0] ERR_ORDER     = 3'd3;
   localparam logic [2:0] ERR_TIMEOUT   = 3'd4;

   typedef enum logic [1:0] {
      S_WATCH = 2'd0,
      S_REQ   = 2'd1,
      S_WAIT  = 2'd2,
      S_FIN   = 2'd3
   } state_t;

endpackage

// File: rtl/order_cmp.sv
// Neighbour ordering check for the sorted-array scan.
//   prev : element i
//   cur  : element i+1
//   ok   : 1 when the pair respects the configured order
module order_cmp #(
   parameter int DATA_W      = 32,
   parameter int DESCENDING  = 0,
   parameter int SIGNED_CMP  = 1,
   parameter int ALLOW_EQUAL = 0
) (
   input  logic [DATA_W-1:0] prev,
   input  logic [DATA_W-1:0] cur,
   output logic              ok
);

   logic lt;
   logic eq;
   logic gt;

   always_comb begin
      eq = (prev == cur);
      if (SIGNED_CMP != 0) lt = ($signed(prev) < $signed(cur));
      else                 lt = (prev < cur);
      gt = !lt && !eq;
      if (DESCENDING != 0) ok = gt || ((ALLOW_EQUAL != 0) && eq);
      else                 ok = lt || ((ALLOW_EQUAL != 0) && eq);
   end

endmodule

// File: rtl/sort_result_checker.sv
// Run monitor for the single-cycle CPU: waits for the halt PC, checks the
// overflow flag, then reads NUM_WORDS words from data memory and verifies
// they are ordered. Result is sticky until reset.
//   clk, rst      : clock, synchronous active-low reset
//   pc, overflow  : CPU observation inputs (used only while watching)
//   mem_req/addr  : one-cycle read request, byte address
//   mem_rvalid/rdata : read response, any latency >= 1
//   done, pass, err_code, fail_index : result
module sort_result_checker
   import cpu_check_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int BASE_ADDR   = 512,
   parameter int NUM_WORDS   = 12,
   parameter int DONE_PC     = 104,
   parameter int DESCENDING  = 0,
   parameter int SIGNED_CMP  = 1,
   parameter int ALLOW_EQUAL = 0,
   parameter int EXPECT_OVF  = 1,
   parameter int MAX_CYCLES  = 100000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc,
   input  logic              overflow,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              done,
   output logic              pass,
   output logic [2:0]        err_code,
   output logic [15:0]       fail_index
);

   localparam logic [ADDR_W-1:0] DONE_PC_A = ADDR_W'(DONE_PC);
   localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE_ADDR);
   localparam logic [15:0]       LAST_IDX  = 16'(NUM_WORDS - 1);
   localparam logic [31:0]       WD_LIMIT  = 32'(MAX_CYCLES);
   localparam logic              EXP_OVF   = (EXPECT_OVF != 0);

   state_t             state, state_n;
   logic [15:0]        idx, idx_n;
   logic [DATA_W-1:0]  prev, prev_n;
   logic [31:0]        wd_cnt, wd_cnt_n;
   logic               done_n, pass_n;
   logic [2:0]         err_n;
   logic [15:0]        fidx_n;
   logic               pair_ok;

   order_cmp #(
      .DATA_W      (DATA_W),
      .DESCENDING  (DESCENDING),
      .SIGNED_CMP  (SIGNED_CMP),
      .ALLOW_EQUAL (ALLOW_EQUAL)
   ) u_cmp (
      .prev (prev),
      .cur  (mem_rdata),
      .ok   (pair_ok)
   );

   // Request is a pure decode of REQ, so it lasts exactly one cycle and
   // drops to zero (address included) the moment reset returns to WATCH.
   assign mem_req  = (state == S_REQ);
   assign mem_addr = (state == S_REQ) ? (BASE_A + ADDR_W'({idx, 2'b00})) : '0;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= S_WATCH;
         idx        <= '0;
         prev       <= '0;
         wd_cnt     <= '0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_code   <= ERR_NONE;
         fail_index <= '0;
      end else begin
         state      <= state_n;
         idx        <= idx_n;
         prev       <= prev_n;
         wd_cnt     <= wd_cnt_n;
         done       <= done_n;
         pass       <= pass_n;
         err_code   <= err_n;
         fail_index <= fidx_n;
      end
   end

   always_comb begin
      state_n  = state;
      idx_n    = idx;
      prev_n   = prev;
      wd_cnt_n = wd_cnt;
      done_n   = done;
      pass_n   = pass;
      err_n    = err_code;
      fidx_n   = fail_index;

      case (state)
         S_WATCH: begin
            if (pc == DONE_PC_A) begin
               if (overflow != EXP_OVF) begin
                  state_n = S_FIN;
                  done_n  = 1'b1;
                  pass_n  = 1'b0;
                  err_n   = EXP_OVF ? ERR_MISS_OVF : ERR_UNEXP_OVF;
                  fidx_n  = '0;
               end else if (NUM_WORDS == 1) begin
                  // A single element is trivially ordered; no read needed.
                  state_n = S_FIN;
                  done_n  = 1'b1;
                  pass_n  = 1'b1;
                  err_n   = ERR_NONE;
                  fidx_n  = '0;
               end else begin
                  idx_n   = '0;
                  state_n = S_REQ;
               end
            end else if (overflow) begin
               state_n = S_FIN;
               done_n  = 1'b1;
               pass_n  = 1'b0;
               err_n   = ERR_UNEXP_OVF;
               fidx_n  = '0;
            end else if ((MAX_CYCLES != 0) && (wd_cnt == WD_LIMIT)) begin
               state_n = S_FIN;
               done_n  = 1'b1;
               pass_n  = 1'b0;
               err_n   = ERR_TIMEOUT;
               fidx_n  = '0;
            end else begin
               wd_cnt_n = wd_cnt + 32'd1;
            end
         end

         S_REQ: state_n = S_WAIT;

         // Only WAIT looks at mem_rvalid, so a response coinciding with the
         // request cycle, or arriving after reset, is dropped.
         S_WAIT: begin
            if (mem_rvalid) begin
               if (idx == 16'd0) begin
                  prev_n  = mem_rdata;
                  idx_n   = 16'd1;
                  state_n = S_REQ;
               end else if (!pair_ok) begin
                  state_n = S_FIN;
                  done_n  = 1'b1;
                  pass_n  = 1'b0;
                  err_n   = ERR_ORDER;
                  fidx_n  = idx - 16'd1;
               end else if (idx == LAST_IDX) begin
                  state_n = S_FIN;
                  done_n  = 1'b1;
                  pass_n  = 1'b1;
                  err_n   = ERR_NONE;
                  fidx_n  = '0;
               end else begin
                  prev_n  = mem_rdata;
                  idx_n   = idx + 16'd1;
                  state_n = S_REQ;
               end
            end
         end

         default: state_n = S_FIN;   // FIN holds until reset
      endcase
   end

endmodule
